// File: rtl/kb_event_queue_if.sv
// kb_event_queue_if: PS/2 receiver handshake plus event FIFO head/consumer handshake
interface kb_event_queue_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       nextdata_n;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_valid;
  logic       ev_ready;
  modport master (
    output kb_data, kb_ready, kb_overflow, ev_ready,
    input  nextdata_n, ev_code, ev_ext, ev_valid
  );
  modport slave (
    input  kb_data, kb_ready, kb_overflow, ev_ready,
    output nextdata_n, ev_code, ev_ext, ev_valid
  );
endinterface

// File: rtl/kb_event_queue.sv
// kb_event_queue: PS/2 scan-code decoder with modifier tracking and a FWFT event FIFO
module kb_event_queue #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  kb_event_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ctrl,
  output logic                   shift,
  output logic                   alt,
  output logic                   caps,
  output logic                   held,
  output logic [CNT_W-1:0]       press_cnt,
  output logic                   ev_lost
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, E0, F0, E0F0} st_t;
  st_t st_q, st_d;
  logic nd_q, consume, byte_ok, ext, mk, brk, rep, new_mk, brk_held;
  logic is_ctrl, is_shift, is_alt, is_caps, full, pop, push_ok;
  logic ctrl_d, shift_d, alt_d, caps_d, held_d, lost_d;
  logic ctrl_q, shift_q, alt_q, caps_q, held_q, lost_q;
  logic [7:0] hkey_q;
  logic [CNT_W-1:0] press_q, press_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [8:0] mem [DEPTH];
  // Gating with clrn keeps the strobe high throughout reset regardless of kb_ready
  assign consume = clrn && bus.kb_ready && nd_q;
  assign bus.nextdata_n = !consume;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) st_q <= IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q;
    if (bus.kb_overflow) st_d = IDLE;
    else if (consume)
      st_d = bus.kb_data == 8'hE0 ? E0 :
             bus.kb_data == 8'hF0 ? ((st_q == E0 || st_q == E0F0) ? E0F0 : F0) : IDLE;
  end
  always_comb begin
    byte_ok = consume && !bus.kb_overflow && bus.kb_data != 8'hE0 && bus.kb_data != 8'hF0;
    ext = st_q == E0 || st_q == E0F0;
    mk = byte_ok && (st_q == IDLE || st_q == E0);
    brk = byte_ok && (st_q == F0 || st_q == E0F0);
  end
  // Held-key matching is on scan code only, so a bare repeat of an E0 key's code counts as typematic
  assign rep      = mk && held_q && bus.kb_data == hkey_q;
  assign new_mk   = mk && !rep;
  assign brk_held = brk && bus.kb_data == hkey_q;
  assign is_ctrl  = bus.kb_data == 8'h14;
  assign is_shift = !ext && (bus.kb_data == 8'h12 || bus.kb_data == 8'h59);
  assign is_alt   = bus.kb_data == 8'h11;
  assign is_caps  = !ext && bus.kb_data == 8'h58;
  assign ctrl_d   = new_mk && is_ctrl ? 1'b1 : brk && is_ctrl ? 1'b0 : ctrl_q;
  assign shift_d  = new_mk && is_shift ? 1'b1 : brk && is_shift ? 1'b0 : shift_q;
  assign alt_d    = new_mk && is_alt ? 1'b1 : brk && is_alt ? 1'b0 : alt_q;
  assign caps_d   = caps_q ^ (new_mk && is_caps);
  assign held_d   = new_mk ? 1'b1 : brk_held ? 1'b0 : held_q;
  assign press_d  = press_q + CNT_W'(new_mk);
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign pop      = cnt_q != '0 && bus.ev_ready;
  assign push_ok  = new_mk && (!full || pop);
  assign lost_d   = lost_q || bus.kb_overflow || (new_mk && full && !pop);
  assign cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      nd_q    <= 1'b1;
      ctrl_q  <= 1'b0;
      shift_q <= 1'b0;
      alt_q   <= 1'b0;
      caps_q  <= 1'b0;
      held_q  <= 1'b0;
      lost_q  <= 1'b0;
      hkey_q  <= '0;
      press_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      nd_q    <= bus.nextdata_n;
      ctrl_q  <= ctrl_d;
      shift_q <= shift_d;
      alt_q   <= alt_d;
      caps_q  <= caps_d;
      held_q  <= held_d;
      lost_q  <= lost_d;
      hkey_q  <= new_mk ? bus.kb_data : hkey_q;
      press_q <= press_d;
      rd_q    <= rd_q + AW'(pop);
      wr_q    <= wr_q + AW'(push_ok);
      cnt_q   <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_q] <= {ext, bus.kb_data};
  assign bus.ev_valid = cnt_q != '0;
  assign {bus.ev_ext, bus.ev_code} = bus.ev_valid ? mem[rd_q] : 9'h0;
  assign fifo_count = cnt_q;
  assign ctrl       = ctrl_q;
  assign shift      = shift_q;
  assign alt        = alt_q;
  assign caps       = caps_q;
  assign held       = held_q;
  assign press_cnt  = press_q;
  assign ev_lost    = lost_q;
endmodule

// File: tb/tb_kb_event_queue.sv
// tb_kb_event_queue: table-driven decode checks plus FIFO-full, strobe-spacing and reset sequences
module tb_kb_event_queue;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;
  kb_event_queue_if bus();
  logic [2:0] fifo_count;
  logic       ctrl, shift, alt, caps, held, ev_lost;
  logic [7:0] press_cnt;
  kb_event_queue #(.CNT_W(8), .DEPTH(4)) dut (
    .clk(clk), .clrn(clrn), .bus(bus), .fifo_count(fifo_count),
    .ctrl(ctrl), .shift(shift), .alt(alt), .caps(caps), .held(held),
    .press_cnt(press_cnt), .ev_lost(ev_lost)
  );
  typedef struct {
    logic [7:0] b;
    logic       ov;
    logic       v;
    logic [8:0] ev;
    logic       hd;
    logic [7:0] cnt;
    logic [3:0] mods;
    logic       lost;
  } vec_t;
  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] b, input logic ov, input logic v, input logic [8:0] ev,
                     input logic hd, input logic [7:0] cnt, input logic [3:0] mods, input logic lost);
    tbl.push_back('{b, ov, v, ev, hd, cnt, mods, lost});
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ov);
    bit got = 0;
    @(negedge clk);
    bus.kb_data = b;
    bus.kb_ready = 1'b1;
    bus.kb_overflow = ov;
    for (int i = 0; i < 8 && !got; i++) begin
      #1 got = !bus.nextdata_n;
      @(posedge clk);
    end
    chk($sformatf("strobe_%02h", b), 32'(got), 32'd1);
    @(negedge clk);
    bus.kb_ready = 1'b0;
    bus.kb_overflow = 1'b0;
    #1;
  endtask
  task automatic chk_state(input string t, input logic v, input logic [8:0] ev, input logic hd,
                           input logic [7:0] cnt, input logic [3:0] mods, input logic lost);
    chk({t, ".valid"}, 32'(bus.ev_valid), 32'(v));
    chk({t, ".count"}, 32'(fifo_count), 32'(v));
    if (v) chk({t, ".head"}, {23'd0, bus.ev_ext, bus.ev_code}, 32'(ev));
    chk({t, ".held"}, 32'(held), 32'(hd));
    chk({t, ".press"}, 32'(press_cnt), 32'(cnt));
    chk({t, ".mods"}, 32'({ctrl, shift, alt, caps}), 32'(mods));
    chk({t, ".lost"}, 32'(ev_lost), 32'(lost));
  endtask
  task automatic chk_reset(input string t);
    chk({t, ".nd"}, 32'(bus.nextdata_n), 32'd1);
    chk({t, ".valid"}, 32'(bus.ev_valid), 32'd0);
    chk({t, ".head"}, {23'd0, bus.ev_ext, bus.ev_code}, 32'd0);
    chk({t, ".count"}, 32'(fifo_count), 32'd0);
    chk({t, ".mods"}, 32'({ctrl, shift, alt, caps, held}), 32'd0);
    chk({t, ".press"}, 32'(press_cnt), 32'd0);
    chk({t, ".lost"}, 32'(ev_lost), 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] drain [4];
    bus.kb_data = 8'h00;
    bus.kb_ready = 1'b0;
    bus.kb_overflow = 1'b0;
    bus.ev_ready = 1'b0;
    //   byte  ov  v   head    hd cnt  {c,s,a,k} lost
    add(8'h1C, 0, 1, 9'h01C, 1, 1, 4'b0000, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 1, 4'b0000, 0);
    add(8'h1C, 0, 0, 9'h000, 0, 1, 4'b0000, 0);
    add(8'hE0, 0, 0, 9'h000, 0, 1, 4'b0000, 0);
    add(8'h75, 0, 1, 9'h175, 1, 2, 4'b0000, 0);
    add(8'h75, 0, 0, 9'h000, 1, 2, 4'b0000, 0);
    add(8'h75, 0, 0, 9'h000, 1, 2, 4'b0000, 0);
    add(8'hE0, 0, 0, 9'h000, 1, 2, 4'b0000, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 2, 4'b0000, 0);
    add(8'h75, 0, 0, 9'h000, 0, 2, 4'b0000, 0);
    add(8'h12, 0, 1, 9'h012, 1, 3, 4'b0100, 0);
    add(8'h1C, 0, 1, 9'h01C, 1, 4, 4'b0100, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 4, 4'b0100, 0);
    add(8'h1C, 0, 0, 9'h000, 0, 4, 4'b0100, 0);
    add(8'hF0, 0, 0, 9'h000, 0, 4, 4'b0100, 0);
    add(8'h12, 0, 0, 9'h000, 0, 4, 4'b0000, 0);
    add(8'h58, 0, 1, 9'h058, 1, 5, 4'b0001, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 5, 4'b0001, 0);
    add(8'h58, 0, 0, 9'h000, 0, 5, 4'b0001, 0);
    add(8'h58, 0, 1, 9'h058, 1, 6, 4'b0000, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 6, 4'b0000, 0);
    add(8'h58, 0, 0, 9'h000, 0, 6, 4'b0000, 0);
    add(8'hE0, 0, 0, 9'h000, 0, 6, 4'b0000, 0);
    add(8'h14, 0, 1, 9'h114, 1, 7, 4'b1000, 0);
    add(8'h11, 0, 1, 9'h011, 1, 8, 4'b1010, 0);
    add(8'hE0, 0, 0, 9'h000, 1, 8, 4'b1010, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 8, 4'b1010, 0);
    add(8'h14, 0, 0, 9'h000, 1, 8, 4'b0010, 0);
    add(8'hF0, 0, 0, 9'h000, 1, 8, 4'b0010, 0);
    add(8'h11, 0, 0, 9'h000, 0, 8, 4'b0000, 0);
    add(8'hE0, 0, 0, 9'h000, 0, 8, 4'b0000, 0);
    add(8'h1C, 1, 0, 9'h000, 0, 8, 4'b0000, 1);
    add(8'h1C, 0, 1, 9'h01C, 1, 9, 4'b0000, 1);
    add(8'hF0, 0, 0, 9'h000, 1, 9, 4'b0000, 1);
    add(8'h1C, 0, 0, 9'h000, 0, 9, 4'b0000, 1);
    // reset held with kb_ready asserted: nothing may be consumed
    bus.kb_ready = 1'b1;
    bus.kb_data = 8'h1C;
    repeat (3) @(negedge clk);
    #1 chk_reset("rst0");
    bus.kb_ready = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    bus.ev_ready = 1'b1;
    foreach (tbl[i]) begin
      send_byte(tbl[i].b, tbl[i].ov);
      chk_state($sformatf("v%0d", i), tbl[i].v, tbl[i].ev, tbl[i].hd, tbl[i].cnt, tbl[i].mods, tbl[i].lost);
    end
    // FIFO overfill with consumer stalled
    do_reset();
    bus.ev_ready = 1'b0;
    send_byte(8'h15, 0);
    send_byte(8'h1D, 0);
    send_byte(8'h24, 0);
    send_byte(8'h2D, 0);
    send_byte(8'h2C, 0);
    chk("full.count", 32'(fifo_count), 32'd4);
    chk("full.lost", 32'(ev_lost), 32'd1);
    chk("full.press", 32'(press_cnt), 32'd5);
    chk("full.head", {23'd0, bus.ev_ext, bus.ev_code}, 32'h015);
    // push and pop in the same cycle while full
    @(negedge clk);
    bus.ev_ready = 1'b1;
    bus.kb_data = 8'h33;
    bus.kb_ready = 1'b1;
    #1 chk("pp.strobe", 32'(bus.nextdata_n), 32'd0);
    @(negedge clk);
    bus.kb_ready = 1'b0;
    #1;
    chk("pp.count", 32'(fifo_count), 32'd4);
    chk("pp.press", 32'(press_cnt), 32'd6);
    drain = '{8'h1D, 8'h24, 8'h2D, 8'h33};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), {23'd0, bus.ev_ext, bus.ev_code}, {24'd0, drain[k]});
      @(negedge clk);
      #1;
    end
    chk("drain.valid", 32'(bus.ev_valid), 32'd0);
    chk("drain.count", 32'(fifo_count), 32'd0);
    // kb_ready held high: strobe must alternate, never two low cycles in a row
    bus.kb_data = 8'h33;
    bus.kb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("alt_nd%0d", k), 32'(bus.nextdata_n), 32'(k % 2));
      @(negedge clk);
    end
    bus.kb_ready = 1'b0;
    #1;
    chk("alt.press", 32'(press_cnt), 32'd6);
    chk("alt.count", 32'(fifo_count), 32'd0);
    // reset cuts an E0 prefix
    send_byte(8'hE0, 0);
    @(negedge clk);
    clrn = 1'b0;
    bus.kb_ready = 1'b1;
    bus.kb_data = 8'h1C;
    @(negedge clk);
    #1 chk_reset("rst1");
    @(negedge clk);
    #1 chk_reset("rst2");
    bus.kb_ready = 1'b0;
    clrn = 1'b1;
    send_byte(8'h1C, 0);
    chk_state("post_rst", 1'b1, 9'h01C, 1'b1, 8'd1, 4'b0000, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kb_event_queue.md
KB_EVENT_QUEUE -- requirements
Module: kb_event_queue

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of press counter.
REQ-002 SHALL have parameter DEPTH, default 4, event FIFO entries; power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port kb_data  input  8  byte from PS/2 receiver.
REQ-006 SHALL have port kb_ready  input  1  receiver holds a byte.
REQ-007 SHALL have port kb_overflow  input  1  receiver dropped bytes.
REQ-008 SHALL have port nextdata_n  output  1  active-low one-cycle pop strobe to receiver.
REQ-009 SHALL have port ev_code  output  8  FIFO head scan code.
REQ-010 SHALL have port ev_ext  output  1  FIFO head extended (E0) flag.
REQ-011 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port ev_ready  input  1  consumer accepts head.
REQ-013 SHALL have port fifo_count  output  $clog2(DEPTH)+1  stored entries.
REQ-014 SHALL have ports ctrl, shift, alt, caps  output  1 each  modifier state.
REQ-015 SHALL have port held  output  1  a non-released key is down.
REQ-016 SHALL have port press_cnt  output  CNT_W  count of new key presses.
REQ-017 SHALL have port ev_lost  output  1  sticky lost-event flag.

Function
REQ-018 SHALL consume a byte in a cycle where kb_ready=1 and nextdata_n was 1 in the previous cycle, driving nextdata_n=0 for exactly that cycle; never two consecutive low cycles.
REQ-019 SHALL run prefix FSM states IDLE, E0, F0, E0F0.
REQ-020 SHALL on byte 0xE0 go to E0 from any state.
REQ-021 SHALL on byte 0xF0 go IDLE->F0, E0->E0F0; stay in F0/E0F0.
REQ-022 SHALL on any other byte in IDLE/E0 form a make event {ext=(state==E0), code}, then go IDLE.
REQ-023 SHALL on any other byte in F0/E0F0 form a break event {ext=(state==E0F0), code}, then go IDLE.
REQ-024 SHALL treat a make equal to the stored held key while held=1 as typematic repeat: no count, no push, no modifier change.
REQ-025 SHALL on non-repeat make: press_cnt+1 (modulo 2^CNT_W), push {ext,code}, held=1, store key as held key.
REQ-026 SHALL on break matching held key clear held; other breaks leave held unchanged.
REQ-027 SHALL set ctrl on make of 0x14 (ext or not), shift on non-ext 0x12/0x59, alt on 0x11 (ext or not); matching break clears it.
REQ-028 SHALL toggle caps on non-repeat make of non-ext 0x58; break ignored.
REQ-029 SHALL on push with FIFO full and no pop in same cycle discard the event and set ev_lost; press_cnt still increments.
REQ-030 SHALL on simultaneous push and pop when full accept the push, fifo_count unchanged.
REQ-031 SHALL be first-word-fall-through: ev_valid=(fifo_count!=0); pop when ev_valid&&ev_ready; pop on empty ignored.
REQ-032 SHALL present a pushed event on ev_code/ev_ext with ev_valid=1 the cycle after the consume cycle when FIFO was empty.
REQ-033 SHALL on kb_overflow=1 set ev_lost and force FSM to IDLE that cycle; byte consumed the same cycle is discarded.
REQ-034 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-035 SHALL asynchronously on clrn=0 set FSM IDLE, FIFO empty, fifo_count=0, ev_valid=0, ev_code=0, ev_ext=0, nextdata_n=1, ctrl=shift=alt=caps=0, held=0, press_cnt=0, ev_lost=0.
REQ-036 SHALL hold reset state while clrn=0, ignoring kb_ready, and resume consuming the first cycle after release; a sequence cut by reset is lost.

Verification
REQ-037 Bytes 1C, F0, 1C -> one event {0,1C}, press_cnt=1, held 1 then 0, nextdata_n low once per byte.
REQ-038 Bytes E0, 75, 75, 75, E0, F0, 75 -> one event {1,75}, press_cnt=1, held=0 at end.
REQ-039 Bytes 12, 1C, F0, 1C, F0, 12 -> shift 1 then 0, events {0,12},{0,1C}, press_cnt=2.
REQ-040 Bytes 58, F0, 58, 58, F0, 58 -> caps 1 then 0, press_cnt=2.
REQ-041 DEPTH=4, ev_ready=0, makes 15,1D,24,2D,2C -> fifo_count=4, ev_lost=1, press_cnt=5, head {0,15}; then ev_ready=1 -> 15,1D,24,2D in order.
REQ-042 clrn=0 after byte E0, then byte 1C -> event {0,1C}, all outputs at reset values during reset.
